// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// It holds newd for the transmitter's baud tick, then waits for done_tx or a timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NEWD_HOLD  = 104,
  parameter int unsigned TIMEOUT    = 4096,
  localparam int unsigned IDW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [IDW-1:0]                err_id,
  output logic                          busy,
  output logic [IDW-1:0]                owner,
  output logic                          tx_newd,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_done
);

  localparam int unsigned CNT_MAX = (NEWD_HOLD > TIMEOUT) ? NEWD_HOLD : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam int unsigned IW1     = IDW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                  state_q,   state_d;
  logic [CW-1:0]           cnt_q,     cnt_d;
  logic [IDW-1:0]          last_q,    last_d;
  logic                    tx_done_q;
  logic [NUM_REQ-1:0]      ack_q,     ack_d;
  logic [NUM_REQ-1:0]      done_q,    done_d;
  logic                    err_q,     err_d;
  logic [IDW-1:0]          err_id_q,  err_id_d;
  logic                    busy_q,    busy_d;
  logic [IDW-1:0]          owner_q,   owner_d;
  logic                    tx_newd_q, tx_newd_d;
  logic [DATA_WIDTH-1:0]   tx_din_q,  tx_din_d;

  logic                    win_valid;
  logic [IDW-1:0]          win_id;
  logic [IW1-1:0]          idx;
  logic                    done_rise;

  // Search last+1, last+2, ... wrapping at NUM_REQ; the first hit wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = {1'b0, last_q} + IW1'(off);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (!win_valid && req[idx[IDW-1:0]]) begin
        win_valid = 1'b1;
        win_id    = idx[IDW-1:0];
      end
    end
  end

  assign done_rise = tx_done & ~tx_done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    err_id_d  = err_id_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    tx_newd_d = tx_newd_q;
    tx_din_d  = tx_din_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (win_valid) begin
          tx_din_d       = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
          owner_d        = win_id;
          ack_d[win_id]  = 1'b1;
          tx_newd_d      = 1'b1;
          busy_d         = 1'b1;
          cnt_d          = '0;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        tx_newd_d = 1'b1;
        if (cnt_q == CW'(NEWD_HOLD - 1)) begin
          tx_newd_d = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (done_rise) begin
          done_d[owner_q] = 1'b1;
          last_d          = owner_q;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          err_id_d = owner_q;
          last_d   = owner_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        tx_newd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      tx_done_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      tx_newd_q <= 1'b0;
      tx_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_done_q <= tx_done;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      tx_newd_q <= tx_newd_d;
      tx_din_q  <= tx_din_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_id  = err_id_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign tx_newd = tx_newd_q;
  assign tx_din  = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, newd hold length, done/timeout, fairness, reset abort.
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned NH  = 104;
  localparam int unsigned TO  = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     done;
  logic              err;
  logic [1:0]        err_id;
  logic              busy;
  logic [1:0]        owner;
  logic              tx_newd;
  logic [DW-1:0]     tx_din;
  logic              tx_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .NEWD_HOLD  (NH),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .err_id   (err_id),
    .busy     (busy),
    .owner    (owner),
    .tx_newd  (tx_newd),
    .tx_din   (tx_din),
    .tx_done  (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic grant_check(input int w, input logic [7:0] b);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < 20);
    check("ack_latency", 32'(lat), 32'd1);
    check("ack_onehot", 32'(ack), 32'd1 << w);
    check("owner", 32'(owner), 32'(w));
    check("tx_din", 32'(tx_din), 32'(b));
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_newd", 32'(tx_newd), 32'd1);
    check("grant_no_done", 32'(done), 32'd0);
    check("grant_no_err", 32'(err), 32'd0);
  endtask

  task automatic hold_check(input bit stale);
    int cnt;
    int extra_ack;
    int spurious;
    cnt = 1;
    extra_ack = 0;
    spurious = 0;
    while (cnt < 300) begin
      @(negedge clk);
      if (ack != '0) extra_ack++;
      if (done != '0 || err) spurious++;
      if (!tx_newd) break;
      cnt++;
      if (stale && cnt == 50) tx_done = 1'b1;
      if (stale && cnt == 53) tx_done = 1'b0;
    end
    check("newd_cycles", 32'(cnt), 32'(NH));
    check("hold_extra_ack", 32'(extra_ack), 32'd0);
    check("hold_spurious", 32'(spurious), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_done(input int w, input int delay);
    int bad;
    bad = 0;
    repeat (delay) begin
      @(negedge clk);
      if (done != '0 || err) bad++;
    end
    check("wait_quiet", 32'(bad), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    check("done_onehot", 32'(done), 32'd1 << w);
    check("done_busy", 32'(busy), 32'd0);
    check("done_err", 32'(err), 32'd0);
    tx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int to_cycles;
    int spurious;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_newd", 32'(tx_newd), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // single request
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    req = 4'b0100;
    grant_check(2, 8'hA5);
    req = '0;
    hold_check(1'b0);
    finish_done(2, 1000);
    @(negedge clk);
    check("single_done_pulse", 32'(done), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_no_ack", 32'(ack), 32'd0);

    // pointer fairness
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0010;
    grant_check(1, 8'h22);
    req = '0;
    hold_check(1'b0);
    finish_done(1, 20);
    req = 4'b1001;
    grant_check(3, 8'h44);
    hold_check(1'b0);
    finish_done(3, 20);
    grant_check(0, 8'h11);
    req = '0;
    hold_check(1'b0);
    finish_done(0, 20);

    // timeout with requester 3 pending
    req = 4'b1100;
    grant_check(2, 8'h33);
    req = 4'b1000;
    hold_check(1'b0);
    to_cycles = 0;
    spurious = 0;
    while (!err && to_cycles < 5000) begin
      @(negedge clk);
      to_cycles++;
      if (done != '0) spurious++;
    end
    check("timeout_cycles", 32'(to_cycles), 32'(TO));
    check("timeout_err_id", 32'(err_id), 32'd2);
    check("timeout_no_done", 32'(spurious), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    grant_check(3, 8'h44);
    req = '0;
    check("err_id_held", 32'(err_id), 32'd2);
    hold_check(1'b0);
    finish_done(3, 30);

    // stale tx_done edge during HOLD
    req = 4'b0001;
    grant_check(0, 8'h11);
    req = '0;
    hold_check(1'b1);
    finish_done(0, 40);
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != '0) spurious++;
    end
    check("stale_single_done", 32'(spurious), 32'd0);

    // reset mid-WAIT, then full contention
    req = 4'b0010;
    grant_check(1, 8'h22);
    req = '0;
    hold_check(1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_err_id", 32'(err_id), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_newd", 32'(tx_newd), 32'd0);
    check("midrst_din", 32'(tx_din), 32'd0);
    reset = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NR*DW-1:0] bytes;
      bytes = req_data;
      grant_check(k % 4, bytes[(k % 4)*DW +: DW]);
      if (k == 4) req = '0;
      hold_check(1'b0);
      finish_done(k % 4, 5);
    end
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte requesters. It latches the winning requester's byte and drives the transmitter's `newd`/`din` inputs. It holds `newd` long enough to be sampled by the transmitter's baud-derived internal clock. It then waits for `done_tx`, reports completion or timeout back to the owning requester, and re-arbitrates.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `DATA_WIDTH`, default 8: byte width; must match `uart_tx`.
- `NEWD_HOLD`, default 104: `clk` cycles that `tx_newd` stays high. Must be ≥ `clk_freq/baudrate` of the attached `uart_tx`.
- `TIMEOUT`, default 4096: `clk` cycles allowed in WAIT for `tx_done` before abort.
- `clk` input 1: system clock; same clock that feeds `uart_tx`.
- `reset` input 1: synchronous, active-low.
- `req` input `NUM_REQ`: per-requester "byte ready"; level.
- `req_data` input `NUM_REQ*DATA_WIDTH`: byte i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ack` output `NUM_REQ`: one-cycle pulse; byte i latched, so requester may change data or drop `req`.
- `done` output `NUM_REQ`: one-cycle pulse; byte i fully transmitted.
- `err` output 1: one-cycle pulse on timeout.
- `err_id` output `IDW`: owner index at timeout; held until the next `err`.
- `busy` output 1: high in HOLD and WAIT.
- `owner` output `IDW`: index of current/last granted requester.
- `tx_newd` output 1: to `uart_tx.newd`.
- `tx_din` output `DATA_WIDTH`: to `uart_tx.din`; stable whenever `busy`.
- `tx_done` input 1: from `uart_tx.done_tx`; level, rising edge significant.
- `IDW` = max(1, clog2(`NUM_REQ`)).

## Operation
- FSM states: IDLE, HOLD, WAIT.
- Round-robin pointer `last` has reset value `NUM_REQ-1`, so requester 0 has first priority. The search order is `last+1`, `last+2`, … mod `NUM_REQ`.
- **IDLE** (`busy=0`), when any `req` bit is set:
  - select the winner w;
  - register `tx_din` ← byte w and `owner` ← w;
  - pulse `ack[w]` and assert `tx_newd`;
  - clear the counter; go to HOLD.
- **HOLD**:
  - `tx_newd=1`; counter increments each cycle.
  - When the counter reaches `NEWD_HOLD-1`, drive `tx_newd` ← 0, clear the counter, go to WAIT.
- **WAIT**:
  - `tx_done_q` is registered every cycle; a rise is `tx_done & !tx_done_q`.
  - On a rise: pulse `done[owner]`, `last` ← `owner`, go to IDLE.
  - Otherwise, when the counter reaches `TIMEOUT-1`: pulse `err`, `err_id` ← `owner`, `last` ← `owner`, go to IDLE. No `done` pulse.
- `tx_done` edges seen in IDLE or HOLD are ignored and never produce `done`.
- `req` of any requester is ignored while `busy`. A requester holding `req` high after `ack` is treated as requesting another byte. Round robin guarantees it is re-served only after every other pending requester.
- `req` dropped before a grant: no `ack`, no side effects.
- Counter width: clog2(max(`NEWD_HOLD`, `TIMEOUT`)) + 1. No wrap is possible within a state.
- Reset (sampled low on a `clk` edge):
  - all outputs go to 0 on that edge: `ack`, `done`, `err`, `err_id`, `busy`, `owner`, `tx_newd`, `tx_din`;
  - state ← IDLE, counter ← 0, `tx_done_q` ← 0, `last` ← `NUM_REQ-1`.
  - A reset mid-HOLD or mid-WAIT aborts silently, with no `done` or `err`.

## Timing
- `req` high at edge n (IDLE) → `ack[w]`, `busy`, `tx_newd` and `tx_din` all valid after edge n+1.
- `tx_newd` is high for exactly `NEWD_HOLD` cycles.
- WAIT entry edge m; `tx_done` rises, first sampled high at edge k → `done[owner]` high after edge k for one cycle. IDLE resumes the same edge.
- Earliest next `ack` is one cycle after `done`/`err`. Minimum grant-to-grant spacing is `NEWD_HOLD` + 2 cycles.
- Timeout: `err` asserts after edge m + `TIMEOUT`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single request:** `req=4'b0100`, byte2=0xA5.
  - `ack[2]` pulses next cycle; `owner=2`, `tx_din=0xA5`.
  - `tx_newd` high exactly 104 cycles.
  - Model raises `tx_done` 1000 cycles later → `done[2]` one-cycle pulse; `busy` low.
- **Full contention:** `req=4'b1111` held, bytes 0x11/0x22/0x33/0x44.
  - Grant order 0,1,2,3,0; `tx_din` matches each owner; exactly one `ack` per transfer.
- **Pointer fairness:** after a transfer for requester 1, `req=4'b1001` → grant 3 first, then 0.
- **Timeout:** `tx_done` held low.
  - `err` pulses exactly 4096 cycles after WAIT entry, `err_id=owner`; no `done`.
  - Next pending requester granted one cycle later.
- **Stale edge:** `tx_done` pulses during HOLD → no `done`; a later rise in WAIT yields exactly one `done`.
- **Reset mid-WAIT:** `reset=0` for one cycle.
  - All outputs 0 next edge; no `done`/`err`.
  - With `req=4'b1111`, first grant after reset goes to requester 0.
